// File: rtl/step_ctx_scheduler.sv
// step_ctx_scheduler
//   Shares one combinational step-function datapath among NCTX contexts.
//   Each context keeps its own state register. On each cycle, at most one
//   requesting context is picked round-robin. Its state and input go to the
//   datapath, the next-state is written back, and the step output is
//   registered.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   req        per-context step request (level)
//   req_in     per-context 1-bit step input, used when that context is granted
//   restart    per-context restart pulse (reload RST_STATE, clear halted)
//   dp_arg     state of the selected context, sent to the datapath
//   dp_in      req_in of the selected context, sent to the datapath
//   dp_res     datapath result {cont, out[OW-1:0], next[SW-1:0]}
//   grant      one-hot selected context (combinational), 0 when none
//   out_valid  registered step-result valid
//   out_ctx    context index of out_data
//   out_data   registered step output
//   halted     per-context halted flag (registered)
//
// Build option
//   STEP_SCHED_HALT_EN : a step that returns cont=0 halts its context until
//                        that context is restarted. When this macro is not
//                        defined, cont is ignored and halted is always 0.
module step_ctx_scheduler #(
  parameter int unsigned     NCTX      = 4,
  parameter int unsigned     SW        = 8,
  parameter int unsigned     OW        = 8,
  parameter logic [SW-1:0]   RST_STATE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCTX-1:0]         req,
  input  logic [NCTX-1:0]         req_in,
  input  logic [NCTX-1:0]         restart,
  output logic [SW-1:0]           dp_arg,
  output logic                    dp_in,
  input  logic [SW+OW:0]          dp_res,
  output logic [NCTX-1:0]         grant,
  output logic                    out_valid,
  output logic [$clog2(NCTX)-1:0] out_ctx,
  output logic [OW-1:0]           out_data,
  output logic [NCTX-1:0]         halted
);

  localparam int unsigned   CW     = $clog2(NCTX);
  localparam logic [CW:0]   NCTX_W = (CW+1)'(NCTX);
  localparam logic [CW-1:0] LAST   = CW'(NCTX - 1);

  logic [SW-1:0]   state [NCTX];
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   sel;
  logic [CW:0]     idx;
  logic            found;
  logic [NCTX-1:0] elig;

  logic            cont;
  logic [OW-1:0]   res_out;
  logic [SW-1:0]   res_next;

  assign cont     = dp_res[SW+OW];
  assign res_out  = dp_res[SW+OW-1:SW];
  assign res_next = dp_res[SW-1:0];

  // A context that is restarting in this cycle is excluded from selection.
  // This makes restart win over a grant without any extra arbitration.
  assign elig = req & ~halted & ~restart;

  // Round-robin search. Start at ptr and wrap; the first eligible index wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NCTX; k++) begin
      idx = {1'b0, ptr} + (CW+1)'(k);
      if (idx >= NCTX_W) idx = idx - NCTX_W;
      if (!found && elig[idx[CW-1:0]]) begin
        found = 1'b1;
        sel   = idx[CW-1:0];
      end
    end
    if (rst) found = 1'b0;
  end

  always_comb begin
    grant = '0;
    if (found) grant[sel] = 1'b1;
  end

  assign dp_arg = found ? state[sel] : state[0];
  assign dp_in  = found ? req_in[sel] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCTX; i++) state[i] <= RST_STATE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_ctx   <= '0;
      out_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < NCTX; i++) begin
        if (restart[i]) state[i] <= RST_STATE;
      end
      // sel is never a restarting context, so these two writes cannot
      // target the same entry.
      if (found) begin
        state[sel] <= res_next;
        out_data   <= res_out;
        out_ctx    <= sel;
        ptr        <= (sel == LAST) ? '0 : sel + 1'b1;
      end
      out_valid <= found;
    end
  end

`ifdef STEP_SCHED_HALT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= '0;
    end else begin
      for (int unsigned i = 0; i < NCTX; i++) begin
        if (restart[i]) halted[i] <= 1'b0;
      end
      if (found && !cont) halted[sel] <= 1'b1;
    end
  end
`else
  logic unused_cont;
  assign unused_cont = cont;
  assign halted      = '0;
`endif

endmodule

// File: tb/tb_step_ctx_scheduler.sv
module tb_step_ctx_scheduler;

`ifdef STEP_SCHED_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req_in, restart;
  logic [7:0] dp_arg;
  logic       dp_in;
  logic [16:0] dp_res;
  logic [3:0] grant;
  logic       out_valid;
  logic [1:0] out_ctx;
  logic [7:0] out_data;
  logic [3:0] halted;

  bit halt_mode = 1'b0;

  always #5 clk = ~clk;

  // Bench datapath model: the output is the argument, and the next state is
  // the argument plus 1.
  assign dp_res = {!(halt_mode && dp_arg == 8'h02), dp_arg, dp_arg + 8'h01};

  step_ctx_scheduler #(.NCTX(4), .SW(8), .OW(8), .RST_STATE(8'h00)) dut (
    .clk(clk), .rst(rst), .req(req), .req_in(req_in), .restart(restart),
    .dp_arg(dp_arg), .dp_in(dp_in), .dp_res(dp_res), .grant(grant),
    .out_valid(out_valid), .out_ctx(out_ctx), .out_data(out_data),
    .halted(halted)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_state [4];
  logic [3:0] m_halt;
  int         m_ptr;
  logic       m_ov;
  logic [1:0] m_octx;
  logic [7:0] m_odata;

  // Sampled DUT values from the latest cycle
  logic [3:0] s_grant, s_halted;
  logic [7:0] s_dp_arg, s_odata;
  logic       s_ov;
  logic [1:0] s_octx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_state[i] = 8'h00;
    m_halt = '0; m_ptr = 0; m_ov = 0; m_octx = 0; m_odata = 0;
  endtask

  // One clock cycle: drive the inputs, sample and check against the model,
  // then advance the model at the rising edge.
  task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] rin,
                     input logic [3:0] rs, input bit chk_en);
    int  msel;
    bit  mfound;
    bit  mcont;
    @(negedge clk);
    rst = r; req = rq; req_in = rin; restart = rs;
    #1;
    mfound = 0; msel = 0;
    if (!r) begin
      for (int k = 0; k < 4; k++) begin
        int ix;
        ix = (m_ptr + k) % 4;
        if (!mfound && rq[ix] && !m_halt[ix] && !rs[ix]) begin
          mfound = 1; msel = ix;
        end
      end
    end
    s_grant = grant; s_dp_arg = dp_arg; s_ov = out_valid;
    s_octx = out_ctx; s_odata = out_data; s_halted = halted;
    if (chk_en) begin
      chk("grant",     grant,     mfound ? (32'd1 << msel) : 32'd0);
      chk("dp_arg",    dp_arg,    mfound ? m_state[msel] : m_state[0]);
      chk("dp_in",     dp_in,     mfound ? rin[msel] : 1'b0);
      chk("out_valid", out_valid, m_ov);
      chk("out_ctx",   out_ctx,   m_octx);
      chk("out_data",  out_data,  m_odata);
      chk("halted",    halted,    m_halt);
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) if (rs[i]) begin m_state[i] = 8'h00; m_halt[i] = 1'b0; end
      if (mfound) begin
        mcont   = !(halt_mode && m_state[msel] == 8'h02);
        m_odata = m_state[msel];
        m_octx  = 2'(msel);
        m_ov    = 1'b1;
        if (HALT_ON && !mcont) m_halt[msel] = 1'b1;
        m_state[msel] = m_state[msel] + 8'h01;
        m_ptr = (msel + 1) % 4;
      end else begin
        m_ov = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic [3:0] g;
    logic       ov;
    logic [1:0] c;
    logic [7:0] d;
  } vec_t;

  vec_t tbl [25];

  initial begin
    rst = 1'b1; req = '0; req_in = '0; restart = '0;
    model_reset();

    // Reset, idle, full request, then alternating request.
    tbl[0] = '{1, 4'h0, 4'h0, 0, 0, 8'h00};
    for (int i = 1; i <= 5; i++) tbl[i] = '{0, 4'h0, 4'h0, 0, 0, 8'h00};
    tbl[6]  = '{0, 4'hF, 4'h1, 0, 0, 8'h00};
    tbl[7]  = '{0, 4'hF, 4'h2, 1, 0, 8'h00};
    tbl[8]  = '{0, 4'hF, 4'h4, 1, 1, 8'h00};
    tbl[9]  = '{0, 4'hF, 4'h8, 1, 2, 8'h00};
    tbl[10] = '{0, 4'hF, 4'h1, 1, 3, 8'h00};
    tbl[11] = '{0, 4'hF, 4'h2, 1, 0, 8'h01};
    tbl[12] = '{0, 4'hF, 4'h4, 1, 1, 8'h01};
    tbl[13] = '{0, 4'hF, 4'h8, 1, 2, 8'h01};
    tbl[14] = '{0, 4'h0, 4'h0, 1, 3, 8'h01};
    tbl[15] = '{1, 4'h0, 4'h0, 0, 3, 8'h01};
    tbl[16] = '{0, 4'h5, 4'h1, 0, 0, 8'h00};
    tbl[17] = '{0, 4'h5, 4'h4, 1, 0, 8'h00};
    tbl[18] = '{0, 4'h5, 4'h1, 1, 2, 8'h00};
    tbl[19] = '{0, 4'h5, 4'h4, 1, 0, 8'h01};
    tbl[20] = '{0, 4'h5, 4'h1, 1, 2, 8'h01};
    tbl[21] = '{0, 4'h5, 4'h4, 1, 0, 8'h02};
    tbl[22] = '{0, 4'h2, 4'h2, 1, 2, 8'h02};
    tbl[23] = '{0, 4'h0, 4'h0, 1, 1, 8'h00};
    tbl[24] = '{0, 4'h0, 4'h0, 0, 1, 8'h00};

    cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].r, tbl[i].rq, 4'($urandom), 4'h0, 1'b1);
      chk($sformatf("row%0d_grant", i), s_grant, tbl[i].g);
      chk($sformatf("row%0d_ov", i),    s_ov,    tbl[i].ov);
      chk($sformatf("row%0d_ctx", i),   s_octx,  tbl[i].c);
      chk($sformatf("row%0d_data", i),  s_odata, tbl[i].d);
      chk($sformatf("row%0d_halt", i),  s_halted, 4'h0);
    end

    // Halt on cont=0, then recover with restart.
    halt_mode = 1'b1;
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'h2, 4'h0, 4'h0, 1'b1);
      chk("h_grant_ctx1", s_grant, 4'h2);
    end
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk("h_out_data", s_odata, 8'h02);
    chk("h_out_ctx",  s_octx,  2'd1);
    chk("h_halted1",  s_halted[1], HALT_ON);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 4'hF, 4'($urandom), 4'h0, 1'b1);
`ifdef STEP_SCHED_HALT_EN
      chk("h_no_grant1", s_grant[1], 1'b0);
`endif
    end
    cyc(1'b0, 4'h0, 4'h0, 4'h2, 1'b1);
    cyc(1'b0, 4'h2, 4'h2, 4'h0, 1'b1);
    chk("r_halted1", s_halted[1], 1'b0);
    chk("r_grant",   s_grant, 4'h2);
    chk("r_dp_arg",  s_dp_arg, 8'h00);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk("r_out_data", s_odata, 8'h00);
    chk("r_out_ctx",  s_octx, 2'd1);

    // Reset in the middle of a stream.
    halt_mode = 1'b0;
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'hF, 4'h0, 4'h0, 1'b1);
    cyc(1'b1, 4'hF, 4'h0, 4'h0, 1'b1);
    chk("m_rst_grant", s_grant, 4'h0);
    cyc(1'b0, 4'hF, 4'h0, 4'h0, 1'b1);
    chk("m_ov_after_rst", s_ov, 1'b0);
    chk("m_first_grant",  s_grant, 4'h1);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk("m_first_data", s_odata, 8'h00);
    chk("m_first_ov",   s_ov, 1'b1);

    // Restart wins over a grant in the same cycle.
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h1, 4'h0, 4'h0, 1'b1);
    cyc(1'b0, 4'h1, 4'h0, 4'h1, 1'b1);
    chk("x_grant_blocked", s_grant, 4'h0);
    chk("x_prev_data",     s_odata, 8'h02);
    cyc(1'b0, 4'h1, 4'h0, 4'h0, 1'b1);
    chk("x_grant", s_grant, 4'h1);
    chk("x_arg",   s_dp_arg, 8'h00);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk("x_data",  s_odata, 8'h00);

    // Random traffic against the reference model.
    halt_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [3:0] rs;
      r  = ($urandom_range(0, 49) == 0);
      rs = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      cyc(r, 4'($urandom), 4'($urandom), rs, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/step_ctx_scheduler.md
Name: step_ctx_scheduler

Overview:
Time-multiplexes one combinational step-function datapath (arg state in; {continue, out, next-state} out) across NCTX independent contexts. Owns each context's state register and chooses one requesting context per cycle by round-robin. Drives the shared datapath, writes back next-state and registers the step output. Sits between the requester fabric and a single compiled step-function instance.

Parameters:
NCTX, 4, number of contexts (2..16)
SW, 8, state width per context
OW, 8, output width per step
RST_STATE, 8'h00 (SW bits), state loaded at reset and on restart

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req  input  NCTX  per-context step request (level)
req_in  input  NCTX  per-context 1-bit step input, sampled when granted
restart  input  NCTX  per-context restart pulse
dp_arg  output  SW  state of selected context to datapath
dp_in  output  1  req_in of selected context to datapath
dp_res  input  1+OW+SW  datapath result {cont, out[OW-1:0], next[SW-1:0]}, combinational from dp_arg/dp_in
grant  output  NCTX  one-hot selected context, combinational, 0 when none
out_valid  output  1  registered step-result valid
out_ctx  output  clog2(NCTX)  context index of out_data
out_data  output  OW  registered step output
halted  output  NCTX  per-context halted flag (registered)

Behaviour:
- Interface fixed: single clock clk; rst is synchronous and active-high, sampled only on rising clk.
- Reset: state[i]=RST_STATE, halted=0, rr pointer=0, out_valid=0, out_ctx=0, out_data=0. grant=0 while rst=1.
- Eligible[i] = req[i] & ~halted[i] & ~restart[i].
- Selection: first eligible index at or after pointer, wrapping modulo NCTX. No eligible -> grant=0, dp_arg=state[0], dp_in=0, no state change.
- Granted cycle: dp_arg=state[sel], dp_in=req_in[sel]. At clk edge: state[sel]<=dp_res next field; out_data<=dp_res out field; out_ctx<=sel; out_valid<=1; pointer<=(sel+1) mod NCTX.
- Cycle without grant: out_valid<=0; out_data and out_ctx hold.
- Latency: result is visible on out_* one cycle after its grant. Throughput: one step per cycle.
- A context waits at most NCTX-1 grants while eligible (no starvation).
- Restart[i]: at clk edge, state[i]<=RST_STATE and halted[i]<=0. Context i is not eligible that cycle, so restart wins over a grant.
- Pointer is unchanged by cycles without a grant.
- rst mid-operation overrides everything: an in-flight result is discarded (out_valid=0 next cycle).
- Width rules: dp_res fields split exactly as {[SW+OW], [SW+OW-1:SW], [SW-1:0]}. No arithmetic on state in this block.

Optional Feature:
STEP_SCHED_HALT_EN
- Defined: when a granted step returns cont=0, halted[sel]<=1 at the same edge as the writeback. The result is still emitted. The context stays ineligible until restart[sel].
- Undefined: cont is ignored and halted is tied to 0. The restart behaviour is unchanged.

Test Plan:
Bench datapath model: dp_res={1'b1, dp_arg, dp_arg+8'h01}; NCTX=4.
1. rst 2 cycles, req=4'b0000 for 5 cycles -> grant=0, out_valid=0, halted=0 throughout.
2. req=4'b1111 for 8 cycles -> grant sequence 0001,0010,0100,1000,0001,...; out_ctx 0,1,2,3,0,... one cycle later; out_data 00,00,00,00,01,01,01,01.
3. req=4'b0101 for 6 cycles -> grants alternate ctx0/ctx2; out_data 00,00,01,01,02,02; a later step on ctx1 yields out_data 00.
4. HALT_EN, model returns cont=0 when dp_arg==8'h02 -> ctx1 halted[1]=1 after its 3rd grant (out_data 02 emitted). With req=1111 ctx1 is then never granted. restart[1] pulse -> halted[1]=0 and ctx1's next out_data=00.
5. rst asserted for 1 cycle mid req=1111 stream -> next cycle out_valid=0, first grant after rst is 0001, out_data 00.
6. req=4'b0001 and restart=4'b0001 in the same cycle, after ctx0 reached state 03 -> grant=0 that cycle; next cycle grant=0001 and out_data=00.
